// File: rtl/soa_pipe.sv
// Two-stage set-one log adder: adds truncated logs with LSB-AND carry-in,
// fills the truncated low field with a compensation pattern, exports a carry tap.
module soa_pipe #(
  parameter int LW      = 20,
  parameter int M       = 5,
  parameter int EST_POS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LW-M-1:0]  tloga,
  input  logic [LW-M-1:0]  tlogb,
  input  logic [1:0]       comp_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LW-1:0]    sumlog,
  output logic             cin_EST
);

  localparam int N = LW - M;
  localparam int E = EST_POS;
  localparam int U = N - E;

  logic         s1_valid;
  logic [E-1:0] s1_lo;
  logic         s1_c;
  logic [U-1:0] s1_ua;
  logic [U-1:0] s1_ub;
  logic [1:0]   s1_mode;
  logic         s2_valid;

  logic s1_adv;
  logic s2_adv;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         cin;

  assign op_a = {1'b0, tloga[N-1:1]};
  assign op_b = {1'b0, tlogb[N-1:1]};
  assign cin  = tloga[0] & tlogb[0];

  // Low segment is one bit wider so its MSB is the carry into bit EST_POS.
  logic [E:0] lo_a;
  logic [E:0] lo_b;
  logic [E:0] lo_c;
  logic [E:0] lo_sum;

  always_comb begin
    lo_a          = '0;
    lo_b          = '0;
    lo_c          = '0;
    lo_a[E-1:0]   = op_a[E-1:0];
    lo_b[E-1:0]   = op_b[E-1:0];
    lo_c[0]       = cin;
    lo_sum        = lo_a + lo_b + lo_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c     <= 1'b0;
      s1_ua    <= '0;
      s1_ub    <= '0;
      s1_mode  <= 2'b00;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo   <= lo_sum[E-1:0];
        s1_c    <= lo_sum[E];
        s1_ua   <= op_a[N-1:E];
        s1_ub   <= op_b[N-1:E];
        s1_mode <= comp_mode;
      end
    end
  end

  logic [U-1:0] up_c;
  logic [U-1:0] up_sum;
  logic [M-1:0] fill;

  always_comb begin
    up_c    = '0;
    up_c[0] = s1_c;
    up_sum  = s1_ua + s1_ub + up_c;
  end

  // Reserved mode 11 falls into the set-one default.
  always_comb begin
    fill = '1;
    case (s1_mode)
      2'b00: fill = '0;
      2'b10: begin
        fill      = '0;
        fill[M-1] = 1'b1;
      end
      default: fill = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      sumlog   <= '0;
      cin_EST  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        sumlog  <= {up_sum, s1_lo, fill};
        cin_EST <= s1_c;
      end
    end
  end

endmodule

// File: tb/tb_soa_pipe.sv
// Directed and streamed checks of soa_pipe at default parameters and at
// LW=16/M=3/EST_POS=6, against hand values and a behavioural model.
module tb_soa_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid, in_ready, out_valid, out_ready, cin_EST;
  logic [14:0] tloga, tlogb;
  logic [1:0]  comp_mode;
  logic [19:0] sumlog;

  logic        in_valid2, in_ready2, out_valid2, out_ready2, cin_EST2;
  logic [12:0] tloga2, tlogb2;
  logic [1:0]  comp_mode2;
  logic [15:0] sumlog2;

  soa_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .tloga(tloga), .tlogb(tlogb), .comp_mode(comp_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .sumlog(sumlog), .cin_EST(cin_EST)
  );

  soa_pipe #(.LW(16), .M(3), .EST_POS(6)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .tloga(tloga2), .tlogb(tlogb2), .comp_mode(comp_mode2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .sumlog(sumlog2), .cin_EST(cin_EST2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Carry into bit e recovered as S^A^B, independent of how the adder is split.
  function automatic void ref_model(input int lw, input int m, input int e,
                                    input int a, input int b, input int mode,
                                    output int sl, output int ce);
    int n, ci, aa, bb, s, fl;
    n  = lw - m;
    ci = a & b & 1;
    aa = a >> 1;
    bb = b >> 1;
    s  = (aa + bb + ci) & ((1 << n) - 1);
    if (mode == 0)      fl = 0;
    else if (mode == 2) fl = 1 << (m - 1);
    else                fl = (1 << m) - 1;
    sl = (s << m) | fl;
    ce = ((s ^ aa ^ bb) >> e) & 1;
  endfunction

  task automatic run1(input string tag, input logic [14:0] a, input logic [14:0] b,
                      input logic [1:0] mode, input logic [19:0] exp_sl, input logic exp_ce);
    int cnt;
    tloga     = a;
    tlogb     = b;
    comp_mode = mode;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      tick();
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'd1);
    chk({tag, "_sumlog"}, 32'(sumlog), 32'(exp_sl));
    chk({tag, "_cin_est"}, 32'(cin_EST), 32'(exp_ce));
    tick();
  endtask

  logic [14:0] va [8];
  logic [14:0] vb [8];
  logic [1:0]  vm [8];
  int q_sl[$];
  int q_ce[$];

  initial begin
    int sent, rcv, cyc, sl, ce;
    logic        stalled;
    logic [19:0] held_sl;
    logic        held_ce;

    in_valid = 0; out_ready = 1; tloga = 0; tlogb = 0; comp_mode = 0;
    in_valid2 = 0; out_ready2 = 1; tloga2 = 0; tlogb2 = 0; comp_mode2 = 0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sumlog", 32'(sumlog), 32'd0);
    chk("rst_cin_est", 32'(cin_EST), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    run1("basic",    15'h0003, 15'h0001, 2'b01, 20'h0005F, 1'b0);
    run1("tap_m01",  15'h07FF, 15'h0003, 2'b01, 20'h0803F, 1'b1);
    run1("tap_m00",  15'h07FF, 15'h0003, 2'b00, 20'h08020, 1'b1);
    run1("tap_m10",  15'h07FF, 15'h0003, 2'b10, 20'h08030, 1'b1);
    run1("tap_m11",  15'h07FF, 15'h0003, 2'b11, 20'h0803F, 1'b1);
    run1("max",      15'h7FFF, 15'h7FFF, 2'b01, 20'hFFFFF, 1'b1);
    run1("zero",     15'h0000, 15'h0000, 2'b00, 20'h00000, 1'b0);

    // Backpressure stream
    for (int i = 0; i < 8; i++) begin
      va[i] = 15'($urandom_range(0, 32767));
      vb[i] = 15'($urandom_range(0, 32767));
      vm[i] = 2'($urandom_range(0, 3));
    end
    sent = 0; rcv = 0; cyc = 0; stalled = 1'b0; held_sl = '0; held_ce = 1'b0;
    while (rcv < 8 && cyc < 300) begin
      if (stalled) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_sumlog", 32'(sumlog), 32'(held_sl));
        chk("bp_hold_cin_est", 32'(cin_EST), 32'(held_ce));
      end
      in_valid = (sent < 8);
      if (sent < 8) begin
        tloga = va[sent]; tlogb = vb[sent]; comp_mode = vm[sent];
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'(!(q_sl.size() == 2 && !out_ready)));
      if (out_valid && out_ready) begin
        if (q_sl.size() == 0) begin
          chk("bp_spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("bp_sumlog", 32'(sumlog), 32'(q_sl.pop_front()));
          chk("bp_cin_est", 32'(cin_EST), 32'(q_ce.pop_front()));
          rcv++;
        end
      end
      stalled = out_valid && !out_ready;
      held_sl = sumlog;
      held_ce = cin_EST;
      if (in_valid && in_ready) begin
        ref_model(20, 5, 10, int'(tloga), int'(tlogb), int'(comp_mode), sl, ce);
        q_sl.push_back(sl);
        q_ce.push_back(ce);
        sent++;
      end
      tick();
      cyc++;
    end
    chk("bp_received", 32'(rcv), 32'd8);
    chk("bp_leftover", 32'(q_sl.size()), 32'd0);
    in_valid = 0; out_ready = 1;
    tick(); tick(); tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset with both stages full
    tloga = 15'h07FF; tlogb = 15'h0003; comp_mode = 2'b01;
    in_valid = 1; out_ready = 0;
    tick();
    tick();
    in_valid = 0;
    #1;
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sumlog", 32'(sumlog), 32'd0);
    chk("mid_rst_cin_est", 32'(cin_EST), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_mid_rst_no_stale", 32'(out_valid), 32'd0);
    end

    // Parameter sweep on the LW=16 instance
    q_sl.delete();
    q_ce.delete();
    rcv = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid2 = (i < 10);
      if (i < 10) begin
        tloga2 = 13'($urandom_range(0, 8191));
        tlogb2 = 13'($urandom_range(0, 8191));
        comp_mode2 = 2'($urandom_range(0, 3));
      end
      #1;
      if (out_valid2) begin
        if (q_sl.size() == 0) begin
          chk("sw_spurious_valid", 32'(out_valid2), 32'd0);
        end else begin
          chk("sw_sumlog", 32'(sumlog2), 32'(q_sl.pop_front()));
          chk("sw_cin_est", 32'(cin_EST2), 32'(q_ce.pop_front()));
          rcv++;
        end
      end
      if (in_valid2 && in_ready2) begin
        ref_model(16, 3, 6, int'(tloga2), int'(tlogb2), int'(comp_mode2), sl, ce);
        q_sl.push_back(sl);
        q_ce.push_back(ce);
      end
      tick();
    end
    chk("sw_received", 32'(rcv), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
